// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/main-memory arbiter.
// Bus widths, request types and arbiter enums.
package cache_mem_arbiter_pkg;

    localparam int MEM_ADDR_BUS         = 12;
    localparam int MEM_DATA_BUS         = 128;
    localparam int MEM_TRANSFERS_PER_CL = 4;
    localparam int ARB_TAG_DEPTH        = 8;

    typedef enum logic {DMEM_READ, DMEM_WRITE} dmem_rtype_t;
    typedef enum logic {ARB_SRC_IC, ARB_SRC_DC} mem_arb_src_t;
    typedef enum logic {ARB_IDLE, ARB_BURST} mem_arb_state_t;

    function automatic mem_arb_src_t arb_other(mem_arb_src_t s);
        return (s == ARB_SRC_IC) ? ARB_SRC_DC : ARB_SRC_IC;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side handshake bundle of the arbiter.
interface cache_mem_arbiter_if #(
    parameter int AW = cache_mem_arbiter_pkg::MEM_ADDR_BUS,
    parameter int DW = cache_mem_arbiter_pkg::MEM_DATA_BUS
);
    import cache_mem_arbiter_pkg::*;

    logic          ic_req_valid;
    logic          ic_req_ready;
    logic [AW-1:0] ic_req_addr;
    logic          ic_rsp_valid;
    logic [DW-1:0] ic_rsp_data;

    logic          dc_req_valid;
    logic          dc_req_ready;
    logic [AW-1:0] dc_req_addr;
    dmem_rtype_t   dc_req_rtype;
    logic [DW-1:0] dc_req_wdata;
    logic          dc_rsp_valid;
    logic [DW-1:0] dc_rsp_data;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    dmem_rtype_t   mem_req_rtype;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_rsp_valid, ic_rsp_data,
        input  dc_req_valid, dc_req_addr, dc_req_rtype, dc_req_wdata,
        output dc_req_ready, dc_rsp_valid, dc_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_rtype, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_rsp_valid, ic_rsp_data,
        output dc_req_valid, dc_req_addr, dc_req_rtype, dc_req_wdata,
        input  dc_req_ready, dc_rsp_valid, dc_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_rtype, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

endinterface

// File: rtl/cache_mem_arbiter_tag_fifo.sv
// In-order owner-tag FIFO; one bit per outstanding read beat.
module arb_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wp;
    logic [PW:0] rp;
    logic        slot [DEPTH];
    logic        wr_en;
    logic        rd_en;

    assign empty = (wp == rp);
    assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign rd_en = pop && !empty;
    // A pop frees the head slot this cycle, so a push may land even when full.
    assign wr_en = push && (!full || rd_en);
    assign dout  = slot[rp[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + (PW+1)'(1);
            if (rd_en) rp <= rp + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) slot[wp[PW-1:0]] <= din;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin burst arbiter between icache and dcache for one memory port.
module cache_mem_arbiter #(
    parameter int AW        = cache_mem_arbiter_pkg::MEM_ADDR_BUS,
    parameter int DW        = cache_mem_arbiter_pkg::MEM_DATA_BUS,
    parameter int BEATS     = cache_mem_arbiter_pkg::MEM_TRANSFERS_PER_CL,
    parameter int TAG_DEPTH = cache_mem_arbiter_pkg::ARB_TAG_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_mem_arbiter_if.slave  bus
);
    import cache_mem_arbiter_pkg::*;

    localparam int CW = $clog2(BEATS);

    mem_arb_state_t state, state_nx;
    mem_arb_src_t   owner, owner_nx;
    mem_arb_src_t   prio, prio_nx;
    logic [CW-1:0]  cnt, cnt_nx;

    logic           own_valid;
    logic [AW-1:0]  own_addr;
    dmem_rtype_t    own_rtype;
    logic [DW-1:0]  own_wdata;
    logic           rd, stall, go, hs, push, pop;
    logic           head, tag_full, tag_empty;
    dmem_rtype_t    burst_rtype;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            owner <= ARB_SRC_IC;
            prio  <= ARB_SRC_IC;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            prio  <= prio_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        prio_nx  = prio;
        cnt_nx   = cnt;
        unique case (state)
            ARB_IDLE: begin
                if (bus.ic_req_valid || bus.dc_req_valid) begin
                    state_nx = ARB_BURST;
                    cnt_nx   = '0;
                    if (bus.ic_req_valid && bus.dc_req_valid) owner_nx = prio;
                    else if (bus.ic_req_valid)                owner_nx = ARB_SRC_IC;
                    else                                      owner_nx = ARB_SRC_DC;
                end
            end
            ARB_BURST: begin
                if (hs) begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == CW'(BEATS-1)) begin
                        state_nx = ARB_IDLE;
                        prio_nx  = arb_other(owner);
                    end
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    always_comb begin
        own_valid = bus.dc_req_valid;
        own_addr  = bus.dc_req_addr;
        own_rtype = bus.dc_req_rtype;
        own_wdata = bus.dc_req_wdata;
        if (owner == ARB_SRC_IC) begin
            own_valid = bus.ic_req_valid;
            own_addr  = bus.ic_req_addr;
            own_rtype = DMEM_READ;
            own_wdata = '0;
        end
    end

    assign pop   = bus.mem_rsp_valid && !tag_empty;
    assign rd    = (own_rtype == DMEM_READ);
    // A same-cycle pop makes room, so the stalled read beat issues at once.
    assign stall = rd && tag_full && !pop;
    assign go    = (state == ARB_BURST) && !stall;
    assign hs    = go && own_valid && bus.mem_req_ready;
    assign push  = hs && rd;

    always_comb begin
        bus.mem_req_valid = go && own_valid;
        bus.mem_req_addr  = own_addr;
        bus.mem_req_rtype = own_rtype;
        bus.mem_req_wdata = own_wdata;
        bus.ic_req_ready  = go && bus.mem_req_ready && (owner == ARB_SRC_IC);
        bus.dc_req_ready  = go && bus.mem_req_ready && (owner == ARB_SRC_DC);
        bus.ic_rsp_valid  = pop && (mem_arb_src_t'(head) == ARB_SRC_IC);
        bus.dc_rsp_valid  = pop && (mem_arb_src_t'(head) == ARB_SRC_DC);
        bus.ic_rsp_data   = bus.mem_rsp_data;
        bus.dc_rsp_data   = bus.mem_rsp_data;
    end

    arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (owner == ARB_SRC_DC),
        .dout  (head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)                burst_rtype <= DMEM_READ;
        else if (hs && cnt == '0)  burst_rtype <= own_rtype;
    end

    a_rtype_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (hs && cnt != '0) |-> (own_rtype == burst_rtype));

    a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_rsp_valid |-> !tag_empty);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed vector bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ctl = {mem_req_valid, ic_req_ready, dc_req_ready, ic_rsp_valid, dc_rsp_valid}
    typedef struct {
        logic         icv;
        logic [11:0]  ica;
        logic         dcv;
        logic [11:0]  dca;
        logic         dcw;
        logic [127:0] wd;
        logic         mrdy;
        logic         rspv;
        logic [127:0] rspd;
        logic [4:0]   ctl;
        logic [11:0]  ma;
        logic         mw;
        logic [127:0] mwd;
    } vec_t;

    vec_t tv[$];
    int   rs[7] = '{1, 0, 0, 1, 1, 0, 1};
    int   as[7] = '{0, 1, 1, 1, 2, 3, 3};

    function automatic vec_t v(int icv, int ica, int dcv, int dca, int dcw,
                               int wd, int mrdy, int rspv, int rspd,
                               int ctl, int ma, int mw, int mwd);
        vec_t r;
        r.icv  = icv[0];
        r.ica  = ica[11:0];
        r.dcv  = dcv[0];
        r.dca  = dca[11:0];
        r.dcw  = dcw[0];
        r.wd   = 128'(wd);
        r.mrdy = mrdy[0];
        r.rspv = rspv[0];
        r.rspd = 128'(rspd);
        r.ctl  = ctl[4:0];
        r.ma   = ma[11:0];
        r.mw   = mw[0];
        r.mwd  = 128'(mwd);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t x);
        bus.ic_req_valid  = x.icv;
        bus.ic_req_addr   = x.ica;
        bus.dc_req_valid  = x.dcv;
        bus.dc_req_addr   = x.dca;
        bus.dc_req_rtype  = dmem_rtype_t'(x.dcw);
        bus.dc_req_wdata  = x.wd;
        bus.mem_req_ready = x.mrdy;
        bus.mem_rsp_valid = x.rspv;
        bus.mem_rsp_data  = x.rspd;
    endtask

    task automatic ic_burst(input logic [11:0] base);
        int n;
        n = 0;
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = base;
        for (int k = 0; k < 20 && n < 4; k++) begin
            #1;
            if (bus.ic_req_ready) n++;
            step();
            bus.ic_req_addr = base + 12'(n);
        end
        bus.ic_req_valid = 1'b0;
        chk("ic_burst_beats", 128'(n), 128'(4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.ic_req_valid  = 1'b0;
        bus.ic_req_addr   = '0;
        bus.dc_req_valid  = 1'b0;
        bus.dc_req_addr   = '0;
        bus.dc_req_rtype  = DMEM_READ;
        bus.dc_req_wdata  = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;

        // both request together: icache first, one bubble, then dcache
        tv.push_back(v(1, 'h20, 1, 'h40, 0, 0, 1, 0, 0, 'b00000, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            tv.push_back(v(1, 'h20+k, 1, 'h40, 0, 0, 1, 0, 0, 'b11000, 'h20+k, 0, 0));
        tv.push_back(v(0, 0, 1, 'h40, 0, 0, 1, 0, 0, 'b00000, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            tv.push_back(v(0, 0, 1, 'h40+k, 0, 0, 1, 0, 0, 'b10100, 'h40+k, 0, 0));
        for (int k = 0; k < 4; k++)
            tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 'h1000+k, 'b00010, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 'h2000+k, 'b00001, 0, 0, 0));
        // icache read, 2-cycle response latency, dcache write waiting
        tv.push_back(v(1, 'h10, 1, 'h60, 1, 'hA, 1, 0, 0, 'b00000, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            tv.push_back(v(1, 'h10+k, 1, 'h60, 1, 'hA, 1, int'(k >= 2), 'h3000+k-2,
                           (k >= 2) ? 'b11010 : 'b11000, 'h10+k, 0, 0));
        tv.push_back(v(0, 0, 1, 'h60, 1, 'hA, 1, 1, 'h3002, 'b00010, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 'h60, 1, 'hA, 1, 1, 'h3003, 'b10110, 'h60, 1, 'hA));
        for (int k = 1; k < 4; k++)
            tv.push_back(v(0, 0, 1, 'h60+k, 1, 'hA+k, 1, 0, 0, 'b10100, 'h60+k, 1, 'hA+k));
        // dcache read after write: only read beats carry tags
        tv.push_back(v(0, 0, 1, 'h70, 0, 0, 1, 0, 0, 'b00000, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            tv.push_back(v(0, 0, 1, 'h70+k, 0, 0, 1, int'(k >= 2), 'h4000+k-2,
                           (k >= 2) ? 'b10101 : 'b10100, 'h70+k, 0, 0));
        for (int k = 2; k < 4; k++)
            tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 'h4000+k, 'b00001, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 'b00000, 0, 0, 0));
        // memory ready toggling during a dcache burst
        tv.push_back(v(0, 0, 1, 'h80, 0, 0, 1, 0, 0, 'b00000, 0, 0, 0));
        for (int k = 0; k < 7; k++)
            tv.push_back(v(0, 0, 1, 'h80+as[k], 0, 0, rs[k], 0, 0,
                           (rs[k] != 0) ? 'b10100 : 'b10000, 'h80+as[k], 0, 0));
        for (int k = 0; k < 4; k++)
            tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 'h5000+k, 'b00001, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 'b00000, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_state", 128'(dut.state), 128'(ARB_IDLE));
        chk("reset_fifo_empty", 128'(dut.u_tag_fifo.empty), 128'(1));

        foreach (tv[i]) begin
            apply(tv[i]);
            #1;
            chk($sformatf("vec%0d_ctl", i),
                128'({bus.mem_req_valid, bus.ic_req_ready, bus.dc_req_ready,
                      bus.ic_rsp_valid, bus.dc_rsp_valid}), 128'(tv[i].ctl));
            if (tv[i].ctl[4]) begin
                chk($sformatf("vec%0d_addr", i), 128'(bus.mem_req_addr), 128'(tv[i].ma));
                chk($sformatf("vec%0d_rtype", i), 128'(bus.mem_req_rtype), 128'(tv[i].mw));
                chk($sformatf("vec%0d_wdata", i), bus.mem_req_wdata, tv[i].mwd);
            end
            if (tv[i].ctl[1]) chk($sformatf("vec%0d_ic_data", i), bus.ic_rsp_data, tv[i].rspd);
            if (tv[i].ctl[0]) chk($sformatf("vec%0d_dc_data", i), bus.dc_rsp_data, tv[i].rspd);
            step();
        end

        // eight reads outstanding: next read stalls until a response pops
        apply(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ic_burst(12'h100);
        ic_burst(12'h104);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 12'h200;
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_mem_valid", 128'(bus.mem_req_valid), 128'(0));
            chk("stall_ic_ready", 128'(bus.ic_req_ready), 128'(0));
            step();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 128'h6000;
        #1;
        chk("pop_mem_valid", 128'(bus.mem_req_valid), 128'(1));
        chk("pop_ic_ready", 128'(bus.ic_req_ready), 128'(1));
        chk("pop_ic_rsp", 128'(bus.ic_rsp_valid), 128'(1));
        chk("pop_dc_rsp", 128'(bus.dc_rsp_valid), 128'(0));
        chk("pop_rsp_data", bus.ic_rsp_data, 128'h6000);
        chk("pop_addr", 128'(bus.mem_req_addr), 128'h200);
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.ic_req_addr   = 12'h201;
        #1;
        chk("refull_mem_valid", 128'(bus.mem_req_valid), 128'(0));
        bus.ic_req_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // reset at beat 2 of a dcache burst, then icache must win
        ic_burst(12'h300);
        bus.dc_req_valid = 1'b1;
        bus.dc_req_addr  = 12'h400;
        bus.dc_req_rtype = DMEM_READ;
        step();
        #1;
        chk("dc_grant_ready", 128'(bus.dc_req_ready), 128'(1));
        step();
        bus.dc_req_addr = 12'h401;
        step();
        bus.dc_req_addr = 12'h402;
        #1;
        chk("beat2_mem_valid", 128'(bus.mem_req_valid), 128'(1));
        chk("beat2_addr", 128'(bus.mem_req_addr), 128'h402);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 12'h500;
        #1;
        chk("midrst_state", 128'(dut.state), 128'(ARB_IDLE));
        chk("midrst_out", 128'({bus.mem_req_valid, bus.ic_req_ready, bus.dc_req_ready,
                               bus.ic_rsp_valid, bus.dc_rsp_valid}), 128'(0));
        chk("midrst_fifo_empty", 128'(dut.u_tag_fifo.empty), 128'(1));
        step();
        #1;
        chk("postrst_addr", 128'(bus.mem_req_addr), 128'h500);
        chk("postrst_ic_ready", 128'(bus.ic_req_ready), 128'(1));
        chk("postrst_dc_ready", 128'(bus.dc_req_ready), 128'(0));
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;
        rst_n = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
